audio_ram_arbiter: RTL and testbench
====================================

AUDIO_RAM_ARBITER -- requirements
Module: audio_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, audio sample width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have mode  input  2  operating mode: 00 idle/clear, 01 play, 10 record, 11 hold.
REQ-006 SHALL have max_addr  input  ADDR_W  last valid word address.
REQ-007 SHALL have rec_valid  input  1  record sample offered; rec_data  input  DATA_W  sample; rec_ready  output  1  sample accepted this cycle.
REQ-008 SHALL have play_req  input  1  one-cycle pulse requesting the next sample; play_data  output  DATA_W  sample; play_valid  output  1  one-cycle pulse when play_data updates.
REQ-009 SHALL have ram_rdy  input  1  RAM calibrated; ram_addr  output  ADDR_W; ram_wdata  output  DATA_W; ram_we  output  1  one-cycle write strobe.
REQ-010 SHALL have ram_rd_req  output  1; ram_rd_pres  input  1  read data present; ram_rdata  input  DATA_W; ram_rd_ack  output  1  one-cycle acknowledge.
REQ-011 SHALL have busy  output  1  read or write in flight; end_flag  output  1  address reached max_addr.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, RD_REQ, RD_WAIT, RD_ACK.
REQ-013 While ram_rdy=0, SHALL remain in IDLE, hold rec_ready=0, and ignore play_req.
REQ-014 SHALL latch a pending-play flag on play_req; a second play_req while pending or in a read SHALL be dropped.
REQ-015 In IDLE with mode=10 and rec_valid=1, SHALL assert rec_ready for exactly one cycle, register rec_data into ram_wdata, then enter WRITE.
REQ-016 WRITE SHALL assert ram_we for exactly one cycle at the current address, increment the address, and return to IDLE.
REQ-017 In IDLE with mode=01 and the pending-play flag set, SHALL enter RD_REQ, assert ram_rd_req, and hold it through RD_WAIT until ram_rd_pres=1.
REQ-018 On ram_rd_pres=1 in RD_WAIT, SHALL capture ram_rdata into play_data, deassert ram_rd_req, and enter RD_ACK.
REQ-019 RD_ACK SHALL assert ram_rd_ack and play_valid for one cycle, increment the address, clear the pending-play flag, and return to IDLE.
REQ-020 Read latency from entering RD_REQ SHALL be RAM latency + 2 cycles; there is no timeout.
REQ-021 mode=00 SHALL zero the address, clear the pending-play flag and end_flag, and take effect only in IDLE.
REQ-022 mode=11 SHALL hold the address and accept no new transactions.
REQ-023 A mode change mid-transaction SHALL NOT abort it; the transaction completes first.
REQ-024 ram_addr SHALL be a registered copy of the address counter.
REQ-025 busy SHALL be 1 in every state other than IDLE.
REQ-026 The address SHALL increment modulo 2^ADDR_W, except as stated under Configuration.
REQ-027 rec_valid and play_req SHALL never be served in the same cycle; mode alone selects the requester.

Reset
REQ-028 On reset=0 SHALL asynchronously force IDLE, address=0, ram_addr=0, ram_wdata=0, play_data=0, and all strobes (ram_we, ram_rd_req, ram_rd_ack, rec_ready, play_valid) to 0.
REQ-029 On reset=0 SHALL force busy=0, end_flag=0, and the pending-play flag to 0.
REQ-030 Reset asserted mid-read SHALL drop ram_rd_req immediately; a later ram_rd_pres SHALL be ignored until the next RD_REQ.

Configuration
REQ-031 With AUDIO_ARB_WRAP_EN defined, an increment from address=max_addr SHALL wrap to 0 and pulse end_flag for one cycle.
REQ-032 Without AUDIO_ARB_WRAP_EN, an increment at address=max_addr SHALL hold the address, set end_flag sticky until mode=00 or reset, and block further rec_ready and reads.

Verification
REQ-033 Record: mode=10, ram_rdy=1, rec_valid with 0x1234 -> rec_ready 1 cycle, ram_we 1 cycle, ram_addr=0, ram_wdata=0x1234, then address=1.
REQ-034 Play: mode=01, play_req pulse, RAM returns 0xBEEF 3 cycles after ram_rd_req -> play_data=0xBEEF, play_valid and ram_rd_ack 1 cycle, ram_rd_req low.
REQ-035 Boundary: max_addr=3, four writes; with AUDIO_ARB_WRAP_EN -> address=0 and end_flag pulse; without it -> address=3, end_flag sticky, fifth rec_valid never acknowledged.
REQ-036 Mid-read: mode changed 01->00 in RD_WAIT -> read completes with play_valid, then address=0.
REQ-037 Async reset asserted in RD_WAIT -> ram_rd_req=0 without a clock edge; ram_rd_pres after deassertion -> no play_valid.
REQ-038 Not ready: ram_rdy=0 with rec_valid=1 -> rec_ready, ram_we, and busy all stay 0.

Source files
------------

// File: rtl/audio_ram_arbiter.sv
// rtl/audio_ram_arbiter.sv - Record/playback arbiter between audio sample streams and a word-addressed RAM
// Define AUDIO_ARB_WRAP_EN to wrap the address at max_addr instead of stopping there.
`timescale 1ns/1ps
module audio_ram_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] max_addr,
  input  logic              rec_valid,
  input  logic [DATA_W-1:0] rec_data,
  output logic              rec_ready,
  input  logic              play_req,
  output logic [DATA_W-1:0] play_data,
  output logic              play_valid,
  input  logic              ram_rdy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_rd_req,
  input  logic              ram_rd_pres,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_rd_ack,
  output logic              busy,
  output logic              end_flag
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, RD_ACK} state_t;

  localparam logic [1:0] MODE_CLEAR = 2'b00;
  localparam logic [1:0] MODE_PLAY  = 2'b01;
  localparam logic [1:0] MODE_REC   = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] play_data_q, play_data_d;
  logic              pending_q, pending_d;
  logic              end_flag_q, end_flag_d;
  logic              we_q, we_d;
  logic              rd_req_q, rd_req_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rec_ready_q, rec_ready_d;
  logic              play_valid_q, play_valid_d;
  logic              do_inc;
  logic              blocked;

`ifdef AUDIO_ARB_WRAP_EN
  assign blocked = 1'b0;
`else
  // Once the last word has been used, nothing new starts until a clear.
  assign blocked = end_flag_q;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ram_addr_d   = addr_q;
    wdata_d      = wdata_q;
    play_data_d  = play_data_q;
    pending_d    = pending_q;
`ifdef AUDIO_ARB_WRAP_EN
    end_flag_d   = 1'b0;
`else
    end_flag_d   = end_flag_q;
`endif
    we_d         = 1'b0;
    rd_req_d     = 1'b0;
    rd_ack_d     = 1'b0;
    rec_ready_d  = 1'b0;
    play_valid_d = 1'b0;
    do_inc       = 1'b0;

    // pending_q stays set for the whole read, so requests during a read drop here
    if (play_req && ram_rdy && !pending_q) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (mode == MODE_CLEAR) begin
          addr_d     = '0;
          pending_d  = 1'b0;
          end_flag_d = 1'b0;
        end else if (ram_rdy && !blocked) begin
          if (mode == MODE_REC && rec_valid) begin
            rec_ready_d = 1'b1;
            wdata_d     = rec_data;
            state_d     = WRITE;
          end else if (mode == MODE_PLAY && pending_q) begin
            rd_req_d = 1'b1;
            state_d  = RD_REQ;
          end
        end
      end
      WRITE: begin
        we_d    = 1'b1;
        do_inc  = 1'b1;
        state_d = IDLE;
      end
      RD_REQ: begin
        rd_req_d = 1'b1;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        if (ram_rd_pres) begin
          play_data_d  = ram_rdata;
          rd_ack_d     = 1'b1;
          play_valid_d = 1'b1;
          state_d      = RD_ACK;
        end else begin
          rd_req_d = 1'b1;
        end
      end
      RD_ACK: begin
        do_inc    = 1'b1;
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_inc) begin
      if (addr_q == max_addr) begin
`ifdef AUDIO_ARB_WRAP_EN
        addr_d     = '0;
        end_flag_d = 1'b1;
`else
        end_flag_d = 1'b1;
`endif
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      ram_addr_q   <= '0;
      wdata_q      <= '0;
      play_data_q  <= '0;
      pending_q    <= 1'b0;
      end_flag_q   <= 1'b0;
      we_q         <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rec_ready_q  <= 1'b0;
      play_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ram_addr_q   <= ram_addr_d;
      wdata_q      <= wdata_d;
      play_data_q  <= play_data_d;
      pending_q    <= pending_d;
      end_flag_q   <= end_flag_d;
      we_q         <= we_d;
      rd_req_q     <= rd_req_d;
      rd_ack_q     <= rd_ack_d;
      rec_ready_q  <= rec_ready_d;
      play_valid_q <= play_valid_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = wdata_q;
  assign play_data  = play_data_q;
  assign ram_we     = we_q;
  assign ram_rd_req = rd_req_q;
  assign ram_rd_ack = rd_ack_q;
  assign rec_ready  = rec_ready_q;
  assign play_valid = play_valid_q;
  assign end_flag   = end_flag_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_audio_ram_arbiter.sv
// tb/tb_audio_ram_arbiter.sv - Self-checking bench for audio_ram_arbiter
`timescale 1ns/1ps
module tb_audio_ram_arbiter;
  localparam int AW = 26;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [AW-1:0] max_addr;
  logic          rec_valid;
  logic [DW-1:0] rec_data;
  logic          rec_ready;
  logic          play_req;
  logic [DW-1:0] play_data;
  logic          play_valid;
  logic          ram_rdy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_rd_req;
  logic          ram_rd_pres;
  logic [DW-1:0] ram_rdata;
  logic          ram_rd_ack;
  logic          busy;
  logic          end_flag;

  logic          ram_auto;
  logic          man_pres, auto_pres;
  logic [DW-1:0] man_rdata, auto_rdata;

  assign ram_rd_pres = ram_auto ? auto_pres  : man_pres;
  assign ram_rdata   = ram_auto ? auto_rdata : man_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .max_addr(max_addr),
    .rec_valid(rec_valid), .rec_data(rec_data), .rec_ready(rec_ready),
    .play_req(play_req), .play_data(play_data), .play_valid(play_valid),
    .ram_rdy(ram_rdy), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rd_req(ram_rd_req), .ram_rd_pres(ram_rd_pres), .ram_rdata(ram_rdata),
    .ram_rd_ack(ram_rd_ack), .busy(busy), .end_flag(end_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // RAM behaviour: stores every strobed write, answers reads after a random delay
  logic [DW-1:0] mem [0:63];
  initial begin
    int  rd_cnt;
    bit  rd_active;
    auto_pres  = 1'b0;
    auto_rdata = '0;
    rd_active  = 1'b0;
    rd_cnt     = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ram_we) mem[ram_addr[5:0]] = ram_wdata;
      if (!ram_auto) begin
        auto_pres = 1'b0;
        rd_active = 1'b0;
      end else begin
        if (auto_pres && ram_rd_ack) auto_pres = 1'b0;
        if (rd_active) begin
          if (rd_cnt == 0) begin
            auto_pres  = 1'b1;
            auto_rdata = mem[ram_addr[5:0]];
            rd_active  = 1'b0;
          end else begin
            rd_cnt--;
          end
        end else if (ram_rd_req && !auto_pres) begin
          rd_active = 1'b1;
          rd_cnt    = $urandom_range(0, 4);
        end
      end
    end
  end

  task automatic do_write(input logic [DW-1:0] d, input logic [31:0] exp_addr, input string tag);
    bit got;
    got = 1'b0;
    rec_data  = d;
    rec_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = rec_ready;
    end
    rec_valid = 1'b0;
    chk({tag, "_ack"}, 32'(got), 1);
    tick();
    chk({tag, "_rr_one_cycle"}, 32'(rec_ready), 0);
    chk({tag, "_we"}, 32'(ram_we), 1);
    chk({tag, "_addr"}, 32'(ram_addr), exp_addr);
    chk({tag, "_wdata"}, 32'(ram_wdata), 32'(d));
  endtask

  task automatic pulse_play();
    play_req = 1'b1;
    tick();
    play_req = 1'b0;
  endtask

  task automatic wait_rd_req(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = ram_rd_req;
    end
    chk({tag, "_rd_req_seen"}, 32'(got), 1);
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      got = play_valid;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit              got;
    int              n;
    int              extras;
    int              seen;
    logic [DW-1:0]   d;
    logic [DW-1:0]   exp_q[$];

    reset = 1'b0; mode = 2'b00; max_addr = AW'(1000);
    rec_valid = 1'b0; rec_data = '0; play_req = 1'b0; ram_rdy = 1'b1;
    ram_auto = 1'b0; man_pres = 1'b0; man_rdata = '0;

    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_req", 32'(ram_rd_req), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_rec_ready", 32'(rec_ready), 0);
    chk("rst_play_valid", 32'(play_valid), 0);
    chk("rst_end_flag", 32'(end_flag), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_wdata", 32'(ram_wdata), 0);
    chk("rst_play_data", 32'(play_data), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // RAM not calibrated: record offered and play requested, nothing happens
    ram_rdy = 1'b0; mode = 2'b10; rec_valid = 1'b1; rec_data = 16'h5555; play_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      play_req = 1'b0;
      chk("nrdy_rec_ready", 32'(rec_ready), 0);
      chk("nrdy_we", 32'(ram_we), 0);
      chk("nrdy_busy", 32'(busy), 0);
    end
    rec_valid = 1'b0; ram_rdy = 1'b1; mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nrdy_play_ignored", 32'(ram_rd_req), 0);
    end
    mode = 2'b00;
    tick();

    // Record two samples
    mode = 2'b10;
    do_write(16'h1234, 0, "rec0");
    tick();
    chk("rec0_addr_after", 32'(ram_addr), 1);
    chk("rec0_we_low", 32'(ram_we), 0);
    chk("rec0_idle", 32'(busy), 0);
    do_write(16'hA5A5, 1, "rec1");

    // Play with a 3-cycle RAM response
    mode = 2'b01;
    pulse_play();
    wait_rd_req("play");
    chk("play_busy", 32'(busy), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("play_rd_req_held", 32'(ram_rd_req), 1);
      chk("play_no_valid_yet", 32'(play_valid), 0);
    end
    man_rdata = 16'hBEEF; man_pres = 1'b1;
    tick();
    chk("play_valid", 32'(play_valid), 1);
    chk("play_ack", 32'(ram_rd_ack), 1);
    chk("play_data", 32'(play_data), 32'h0000BEEF);
    chk("play_rd_req_low", 32'(ram_rd_req), 0);
    man_pres = 1'b0;
    tick();
    chk("play_valid_one_cycle", 32'(play_valid), 0);
    chk("play_ack_one_cycle", 32'(ram_rd_ack), 0);
    tick();
    chk("play_addr_after", 32'(ram_addr), 3);
    chk("play_idle", 32'(busy), 0);

    // Clear requested mid-read: read still completes, then address clears
    pulse_play();
    wait_rd_req("midrd");
    mode = 2'b00;
    tick();
    man_rdata = 16'h0F0F; man_pres = 1'b1;
    wait_valid(6, got);
    chk("midrd_valid", 32'(got), 1);
    chk("midrd_data", 32'(play_data), 32'h00000F0F);
    man_pres = 1'b0;
    ticks(3);
    chk("midrd_addr_cleared", 32'(ram_addr), 0);

    // Async reset while waiting for read data
    mode = 2'b01;
    pulse_play();
    wait_rd_req("rstrd");
    tick();
    #2 reset = 1'b0;
    #1;
    chk("rstrd_rd_req_drop", 32'(ram_rd_req), 0);
    chk("rstrd_busy_drop", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    man_rdata = 16'hDEAD; man_pres = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (play_valid || ram_rd_ack || busy) seen++;
    end
    chk("rstrd_pres_ignored", 32'(seen), 0);
    man_pres = 1'b0;

    // Hold mode accepts nothing
    mode = 2'b11; rec_valid = 1'b1; rec_data = 16'h7777;
    pulse_play();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rec_ready || busy) seen++;
    end
    chk("hold_no_txn", 32'(seen), 0);
    rec_valid = 1'b0; mode = 2'b00;
    tick();

    // Address boundary at max_addr=3
    max_addr = AW'(3);
    tick();
    mode = 2'b10;
    for (int i = 0; i < 4; i++) do_write(16'($urandom), 32'(i), "bnd");
    chk("bnd_end_flag", 32'(end_flag), 1);
`ifdef AUDIO_ARB_WRAP_EN
    tick();
    chk("bnd_end_pulse", 32'(end_flag), 0);
    chk("bnd_wrap_addr", 32'(ram_addr), 0);
    do_write(16'h5A5A, 0, "bnd_fifth");
`else
    tick();
    chk("bnd_end_sticky", 32'(end_flag), 1);
    chk("bnd_hold_addr", 32'(ram_addr), 3);
    rec_valid = 1'b1; rec_data = 16'h5A5A;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rec_ready || ram_we) seen++;
    end
    rec_valid = 1'b0;
    chk("bnd_fifth_blocked", 32'(seen), 0);
    chk("bnd_end_still", 32'(end_flag), 1);
    mode = 2'b00;
    tick();
    chk("bnd_end_cleared", 32'(end_flag), 0);
`endif
    mode = 2'b00; max_addr = AW'(1000);
    ticks(2);

    // Random record then play back: samples must return in recorded order
    mode = 2'b10;
    n = $urandom_range(4, 10);
    for (int i = 0; i < n; i++) begin
      d = 16'($urandom);
      exp_q.push_back(d);
      do_write(d, 32'(i), "rnd_wr");
      ticks($urandom_range(0, 3));
    end
    mode = 2'b00;
    ticks(2);
    mode = 2'b01;
    ram_auto = 1'b1;
    for (int i = 0; i < n; i++) begin
      pulse_play();
      if ($urandom_range(0, 1) == 1) pulse_play();
      wait_valid(40, got);
      chk("rnd_valid", 32'(got), 1);
      chk("rnd_data", 32'(play_data), 32'(exp_q[i]));
      tick();
    end
    extras = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (play_valid) extras++;
    end
    chk("rnd_dup_dropped", 32'(extras), 0);
    chk("rnd_final_addr", 32'(ram_addr), 32'(n));
    chk("rnd_idle", 32'(busy), 0);
    ram_auto = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
